// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared FSM state encodings for the bit-serial adder
package serial_adder_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/half_adder.sv
// half_adder: library cell, sum and carry of two bits
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/serial_adder_ctrl_slice.sv
// full_adder_slice: one-bit full adder built from two half_adder cells and an OR
module full_adder_slice (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic SUM,
  output logic COUT
);
  logic s1, c1, c2;
  half_adder u_ha0 (.a(A),  .b(B),   .sum(s1),  .carry(c1));
  half_adder u_ha1 (.a(s1), .b(CIN), .sum(SUM), .carry(c2));
  assign COUT = c1 | c2;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder with start/busy/done handshake
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t st_q, st_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, s_sr_q, s_sr_d, sum_q, sum_d, s_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;
  logic s, co, run, idle, ld, last;
  full_adder_slice u_fa (.A(a_sr_q[0]), .B(b_sr_q[0]), .CIN(c_q), .SUM(s), .COUT(co));
  if (WIDTH == 1) begin : g_w1
    assign s_nx = s;
  end else begin : g_wn
    assign s_nx = {s, s_sr_q[WIDTH-1:1]};
  end
  assign last = cnt_q == CW'(WIDTH - 1);
  // next-state: load on accepted start, shift one bit per RUN cycle, latch result on last bit
  always_comb begin
    run    = st_q == ST_RUN;
    idle   = !(run || st_q == ST_DONE);
    ld     = idle && start;
    st_d   = ld ? ST_RUN : (run ? (last ? ST_DONE : ST_RUN) : ST_IDLE);
    a_sr_d = ld ? a : (run ? a_sr_q >> 1 : a_sr_q);
    b_sr_d = ld ? b : (run ? b_sr_q >> 1 : b_sr_q);
    c_d    = ld ? cin : (run ? co : c_q);
    cnt_d  = ld ? '0 : (run ? cnt_q + CW'(1) : cnt_q);
    s_sr_d = run ? s_nx : s_sr_q;
    sum_d  = (run && last) ? s_nx : sum_q;
    cout_d = (run && last) ? co : cout_q;
    busy_d = st_d != ST_IDLE;
    done_d = st_d == ST_DONE;
  end
  // state and registered outputs; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      a_sr_q <= '0;
      b_sr_q <= '0;
      s_sr_q <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      s_sr_q <= s_sr_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      c_q    <= c_d;
      cout_q <= cout_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and exhaustive checks of the bit-serial adder
module tb_serial_adder_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic busy, done, cout;
  logic [3:0] sum;
  int total = 0, bad = 0;
  serial_adder_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
    int lat;
    @(negedge clk);
    chk("done_low", 32'(done), 0);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    chk("latency", 32'(lat), 5);
    chk("busy_done", 32'(busy), 1);
    chk("result", 32'({cout, sum}), 32'(ta) + 32'(tb_) + 32'(tc));
  endtask
  initial begin
    int nd;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_sum", 32'(sum), 0);
      chk("rst_cout", 32'(cout), 0);
    end
    run_op(4'd3, 4'd5, 1'b0);
    run_op(4'd15, 4'd1, 1'b0);
    run_op(4'd15, 4'd15, 1'b1);
    @(negedge clk);
    a = 4'd2; b = 4'd2; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ign_busy", 32'(busy), 1);
    a = 4'd7; b = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("ign_ndone", 32'(nd), 1);
    chk("ign_sum", 32'(sum), 4);
    chk("ign_cout", 32'(cout), 0);
    @(negedge clk);
    a = 4'd9; b = 4'd9; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(cout), 0);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_ndone", 32'(nd), 0);
    run_op(4'd1, 4'd1, 1'b0);
    for (int i = 0; i < 512; i++) run_op(i[3:0], i[7:4], i[8]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
